// File: rtl/i2s_bram_pkg.sv
// Shared definitions for the I2S BRAM writer/reader pair: FSM state encoding and BRAM write constants.
package i2s_bram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        HEADER = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [31:0] BRAM_ADDR_INCREMENT = 32'd4;
    localparam logic [3:0]  BRAM_WE_ALL         = 4'hF;

endpackage

// File: rtl/bram_stream_writer_if.sv
// Sample stream handshake between the audio source (master) and the BRAM writer (slave).
interface bram_stream_writer_if;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/bram_stream_writer.sv
// Captures NUM_WORDS stream samples per armed frame into a BRAM port.
// Optional macro BRAM_STREAM_WRITER_HEADER_EN adds a frame-number header word at BASE_ADDR.
module bram_stream_writer
    import i2s_bram_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    bram_stream_writer_if.slave        s_if,
    input  logic                       arm,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                frame_count,
    output logic [31:0]                BRAM_addr,
    output logic [31:0]                BRAM_din,
    output logic [3:0]                 BRAM_we,
    output logic                       BRAM_en,
    output logic                       BRAM_rst,
    output logic                       BRAM_clk,
    input  logic [31:0]                BRAM_dout
);

`ifdef BRAM_STREAM_WRITER_HEADER_EN
    localparam logic [31:0] HOFS = 32'd4;
`else
    localparam logic [31:0] HOFS = 32'd0;
`endif
    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);

    state_t      r_state;
    logic [15:0] r_index;
    logic [31:0] r_frame_count;
    logic [31:0] r_addr;
    logic [31:0] r_din;
    logic [3:0]  r_we;
    logic        r_en;
    logic        r_bram_rst;

    logic        w_accept;
    logic        w_last;
    logic [31:0] w_payload_addr;
    logic        w_unused_dout;

    assign w_accept       = s_if.s_valid && (r_state == WRITE);
    assign w_last         = (r_index == LAST_IDX);
    assign w_payload_addr = BASE_ADDR + HOFS + BRAM_ADDR_INCREMENT * {16'd0, r_index};
    assign w_unused_dout  = ^BRAM_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_index       <= 16'd0;
            r_frame_count <= 32'd0;
            r_addr        <= 32'd0;
            r_din         <= 32'd0;
            r_we          <= 4'h0;
            r_en          <= 1'b0;
            r_bram_rst    <= 1'b1;
        end else begin
            r_bram_rst <= 1'b0;
            r_en       <= 1'b0;
            r_we       <= 4'h0;
            case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_index <= 16'd0;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_accept) begin
                        r_en    <= 1'b1;
                        r_we    <= BRAM_WE_ALL;
                        r_addr  <= w_payload_addr;
                        r_din   <= s_if.s_data;
                        r_index <= r_index + 16'd1;
                        if (w_last) begin
`ifdef BRAM_STREAM_WRITER_HEADER_EN
                            r_state <= HEADER;
`else
                            r_state <= DONE;
`endif
                        end
                    end
                end
`ifdef BRAM_STREAM_WRITER_HEADER_EN
                // Header carries the number this frame will have once DONE commits it.
                HEADER: begin
                    r_en    <= 1'b1;
                    r_we    <= BRAM_WE_ALL;
                    r_addr  <= BASE_ADDR;
                    r_din   <= r_frame_count + 32'd1;
                    r_state <= DONE;
                end
`endif
                DONE: begin
                    r_frame_count <= r_frame_count + 32'd1;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_if.s_ready = (r_state == WRITE);
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);
    assign frame_count  = r_frame_count;
    assign BRAM_addr    = r_addr;
    assign BRAM_din     = r_din;
    assign BRAM_we      = r_we;
    assign BRAM_en      = r_en;
    assign BRAM_rst     = r_bram_rst;
    assign BRAM_clk     = clk;

endmodule

// File: tb/tb_bram_stream_writer.sv
// Directed bench for bram_stream_writer with NUM_WORDS=4, BASE_ADDR=0.
module tb_bram_stream_writer;

`ifdef BRAM_STREAM_WRITER_HEADER_EN
    localparam int          NHDR = 1;
    localparam logic [31:0] HOFS = 32'd4;
`else
    localparam int          NHDR = 0;
    localparam logic [31:0] HOFS = 32'd0;
`endif

    logic        clk;
    logic        rst;
    logic        arm;
    logic        busy;
    logic        done;
    logic [31:0] frame_count;
    logic [31:0] BRAM_addr;
    logic [31:0] BRAM_din;
    logic [3:0]  BRAM_we;
    logic        BRAM_en;
    logic        BRAM_rst;
    logic        BRAM_clk;
    logic [31:0] BRAM_dout;

    bram_stream_writer_if s_if ();

    bram_stream_writer #(
        .NUM_WORDS (4),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_if        (s_if),
        .arm         (arm),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count),
        .BRAM_addr   (BRAM_addr),
        .BRAM_din    (BRAM_din),
        .BRAM_we     (BRAM_we),
        .BRAM_en     (BRAM_en),
        .BRAM_rst    (BRAM_rst),
        .BRAM_clk    (BRAM_clk),
        .BRAM_dout   (BRAM_dout)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_din[$];
    logic [4:0]  q_ctl[$];
    logic [31:0] frame_data [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Record every cycle in which the BRAM port is enabled or write-strobed.
    always @(negedge clk) begin
        if (BRAM_en || (BRAM_we != 4'h0)) begin
            q_addr.push_back(BRAM_addr);
            q_din.push_back(BRAM_din);
            q_ctl.push_back({BRAM_en, BRAM_we});
        end
        if (done) done_cnt++;
    end

    task automatic run_frame(input bit toggle, input bit poke_arm, input logic [31:0] fc_before);
        int base;
        int dbase;
        bit seen;
        base  = q_addr.size();
        dbase = done_cnt;
        seen  = 1'b0;
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        chk("busy_write", 32'(busy), 32'd1);
        chk("ready_write", 32'(s_if.s_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            s_if.s_valid = 1'b1;
            s_if.s_data  = frame_data[i];
            arm          = poke_arm && (i == 1);
            @(posedge clk); #1;
            arm          = 1'b0;
            s_if.s_valid = 1'b0;
            if (toggle && i < 3) begin
                @(posedge clk); #1;
            end
        end
        chk("ready_after_last", 32'(s_if.s_ready), 32'd0);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("fc_during_done", frame_count, fc_before);
        if (poke_arm) arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        chk("fc_after_done", frame_count, fc_before + 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_stays_idle", 32'(busy), 32'd0);
        chk("done_pulses", 32'(done_cnt - dbase), 32'd1);
        chk("write_count", 32'(q_addr.size() - base), 32'(4 + NHDR));
        for (int i = 0; i < 4; i++) begin
            if (base + i < q_addr.size()) begin
                chk($sformatf("addr%0d", i), q_addr[base+i], HOFS + 32'(4 * i));
                chk($sformatf("din%0d", i), q_din[base+i], frame_data[i]);
                chk($sformatf("en_we%0d", i), 32'(q_ctl[base+i]), 32'h1F);
            end
        end
`ifdef BRAM_STREAM_WRITER_HEADER_EN
        if (base + 4 < q_addr.size()) begin
            chk("hdr_addr", q_addr[base+4], 32'h0);
            chk("hdr_din", q_din[base+4], fc_before + 32'd1);
            chk("hdr_en_we", 32'(q_ctl[base+4]), 32'h1F);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        rst          = 1'b1;
        arm          = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = 32'h0;
        BRAM_dout    = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", 32'(BRAM_en), 32'd0);
        chk("rst_we", 32'(BRAM_we), 32'd0);
        chk("rst_addr", BRAM_addr, 32'd0);
        chk("rst_din", BRAM_din, 32'd0);
        chk("rst_bram_rst", 32'(BRAM_rst), 32'd1);
        chk("rst_ready", 32'(s_if.s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fc", frame_count, 32'd0);

        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("bram_rst_held", 32'(BRAM_rst), 32'd1);
        @(negedge clk);
        chk("bram_rst_release", 32'(BRAM_rst), 32'd0);

        // Frame 1: valid held high, arm poked mid-frame and during done.
        frame_data = '{32'h0000_000A, 32'h0000_000B, 32'h0000_000C, 32'h0000_000D};
        run_frame(1'b0, 1'b1, 32'd0);

        // Frame 2: valid toggling 1,0,1,0.
        frame_data = '{32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_8000, 32'h0000_0001};
        run_frame(1'b1, 1'b0, 32'd1);

        // Reset after two accepts aborts the frame.
        base  = q_addr.size();
        dbase = done_cnt;
        @(posedge clk); #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = 32'h0000_0111;
        @(posedge clk); #1;
        s_if.s_data  = 32'h0000_0222;
        @(posedge clk); #1;
        rst          = 1'b1;
        s_if.s_valid = 1'b0;
        #1;
        chk("abort_en", 32'(BRAM_en), 32'd0);
        chk("abort_we", 32'(BRAM_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(s_if.s_ready), 32'd0);
        chk("abort_fc", frame_count, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_writes", 32'(q_addr.size() - base), 32'd1);
        chk("abort_no_done", 32'(done_cnt - dbase), 32'd0);
        chk("abort_fc_after", frame_count, 32'd0);

        // Fresh arm after the abort restarts at index 0.
        frame_data = '{32'h0000_0AAA, 32'h0000_0BBB, 32'h0000_0CCC, 32'h0000_0DDD};
        run_frame(1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
